// File: rtl/scaler_nn_v2.sv
// Nearest-neighbour video scaler: buffers one source row from the row FIFO,
// re-samples it to the runtime target geometry and reports a DDR3 base address.
module scaler_nn_v2 #(
  parameter int PIX_WIDTH = 16,
  parameter int FIX_LEN   = 15,
  parameter int FRAC_BITS = 8,
  parameter int MAX_H     = 1024,
  parameter int H_STRIDE  = 640,
  parameter int V_MAX     = 360,
  parameter int DDR_AW    = 28
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 frame_start,
  input  logic                 bypass,
  input  logic [FIX_LEN-1:0]   x_scale,
  input  logic [FIX_LEN-1:0]   y_scale,
  input  logic [12:0]          src_h_num,
  input  logic [12:0]          src_v_num,
  input  logic [12:0]          target_h_num,
  input  logic [12:0]          target_v_num,
  input  logic                 fifo_row_rdy,
  input  logic [PIX_WIDTH-1:0] fifo_data,
  output logic                 rd_en,
  output logic [PIX_WIDTH-1:0] pix_data,
  output logic                 data_vaild,
  output logic                 row_done,
  output logic                 frame_done,
  output logic                 busy,
  output logic [DDR_AW-1:0]    DDR3_ADDR
);

  localparam int ACC_W = FIX_LEN + 13;
  localparam int AW    = (MAX_H > 1) ? $clog2(MAX_H) : 1;
  localparam logic [FIX_LEN-1:0] ONE      = FIX_LEN'(1 << FRAC_BITS);
  localparam logic [12:0]        V_MAX_W  = 13'(V_MAX);
  localparam logic [DDR_AW-1:0]  STRIDE_W = DDR_AW'(H_STRIDE);

  typedef enum logic [2:0] {
    IDLE, WAIT_ROW, LOAD, DECIDE, EMIT, ROW_END, DISCARD, DROP
  } state_t;

  state_t               state;
  logic [FIX_LEN-1:0]   xs_q, ys_q;
  logic [12:0]          sh_q, sv_q, th_q, tv_q;
  logic [12:0]          src_row, dst_row, rd_cnt, wr_cnt, px_cnt;
  logic [ACC_W-1:0]     x_acc, y_acc, x_idx, y_idx;
  logic                 we_d, re_q;
  logic [AW-1:0]        raddr_q;
  logic [12:0]          tv_eff;
  logic [PIX_WIDTH-1:0] line_ram [MAX_H];

  // Source indices clamped to the last column / last row of the frame.
  always_comb begin
    tv_eff = bypass ? src_v_num : target_v_num;
    x_idx  = x_acc >> FRAC_BITS;
    if (x_idx > ACC_W'(sh_q - 13'd1)) x_idx = ACC_W'(sh_q - 13'd1);
    y_idx  = y_acc >> FRAC_BITS;
    if (y_idx > ACC_W'(sv_q - 13'd1)) y_idx = ACC_W'(sv_q - 13'd1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      xs_q       <= '0;
      ys_q       <= '0;
      sh_q       <= '0;
      sv_q       <= '0;
      th_q       <= '0;
      tv_q       <= '0;
      src_row    <= '0;
      dst_row    <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      px_cnt     <= '0;
      x_acc      <= '0;
      y_acc      <= '0;
      we_d       <= 1'b0;
      re_q       <= 1'b0;
      raddr_q    <= '0;
      rd_en      <= 1'b0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      DDR3_ADDR  <= '0;
    end else begin
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      we_d       <= rd_en && (state == LOAD);
      case (state)
        IDLE: if (frame_start) begin
          xs_q      <= bypass ? ONE : x_scale;
          ys_q      <= bypass ? ONE : y_scale;
          sh_q      <= src_h_num;
          sv_q      <= src_v_num;
          th_q      <= bypass ? src_h_num : target_h_num;
          tv_q      <= tv_eff;
          DDR3_ADDR <= (tv_eff >= V_MAX_W) ? '0
                                           : STRIDE_W * DDR_AW'(V_MAX_W - tv_eff);
          src_row   <= '0;
          dst_row   <= '0;
          y_acc     <= '0;
          busy      <= 1'b1;
          state     <= WAIT_ROW;
        end
        WAIT_ROW: if (fifo_row_rdy) begin
          rd_cnt <= 13'd1;
          wr_cnt <= '0;
          rd_en  <= (sh_q != '0);
          state  <= LOAD;
        end
        LOAD: begin
          if (rd_en) begin
            if (rd_cnt == sh_q) rd_en  <= 1'b0;
            else                rd_cnt <= rd_cnt + 13'd1;
          end
          // Writes trail the reads by one cycle; the row is complete on the last write.
          if (sh_q == '0) state <= DECIDE;
          else if (we_d) begin
            wr_cnt <= wr_cnt + 13'd1;
            if (wr_cnt == sh_q - 13'd1) state <= DECIDE;
          end
        end
        DECIDE: begin
          if (dst_row == tv_q || th_q == '0) begin
            state <= DISCARD;
          end else if (y_idx == ACC_W'(src_row)) begin
            x_acc  <= '0;
            px_cnt <= '0;
            state  <= EMIT;
          end else begin
            src_row <= src_row + 13'd1;
            state   <= WAIT_ROW;
          end
        end
        EMIT: begin
          if (px_cnt == th_q) begin
            re_q  <= 1'b0;
            state <= ROW_END;
          end else begin
            re_q    <= 1'b1;
            raddr_q <= x_idx[AW-1:0];
            x_acc   <= x_acc + ACC_W'(xs_q);
            px_cnt  <= px_cnt + 13'd1;
          end
        end
        ROW_END: begin
          row_done <= 1'b1;
          dst_row  <= dst_row + 13'd1;
          y_acc    <= y_acc + ACC_W'(ys_q);
          state    <= DECIDE;
        end
        DISCARD: begin
          if ({1'b0, src_row} + 14'd1 >= {1'b0, sv_q}) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (fifo_row_rdy) begin
            src_row <= src_row + 13'd1;
            rd_cnt  <= 13'd1;
            rd_en   <= (sh_q != '0);
            state   <= DROP;
          end
        end
        DROP: begin
          if (!rd_en || rd_cnt == sh_q) begin
            rd_en <= 1'b0;
            state <= DISCARD;
          end else begin
            rd_cnt <= rd_cnt + 13'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we_d && state == LOAD) line_ram[wr_cnt[AW-1:0]] <= fifo_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_vaild <= 1'b0;
      pix_data   <= '0;
    end else begin
      data_vaild <= re_q;
      if (re_q) pix_data <= line_ram[raddr_q];
    end
  end

endmodule

// File: doc/scaler_nn_v2.md
Name: scaler_nn_v2

Overview:
- Parametrised nearest-neighbour video scaler; successor to the fixed 640x360 scaler top.
- Pulls source rows from the upstream row FIFO and buffers one row in an internal line RAM.
- Emits a scaled pixel stream, with runtime source/target dimensions, a bypass mode and a computed DDR3 write base address in place of a hard-coded one.
- Sits between the input row FIFO and the DDR3 write path.

Parameters:
- PIX_WIDTH, 16, pixel bit width.
- FIX_LEN, 15, width of the scale-factor inputs.
- FRAC_BITS, 8, fractional bits of the scale factors; 1.0 = 1<<FRAC_BITS.
- MAX_H, 1024, line RAM depth, i.e. the maximum source width.
- H_STRIDE, 640, DDR3 line stride in address units.
- V_MAX, 360, display height used for vertical centring of the address.
- DDR_AW, 28, DDR3 address width.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- frame_start  in  1  pulse; latches the config and starts a frame.
- bypass  in  1  1 = force scale 1.0 and target = source.
- x_scale  in  FIX_LEN  horizontal step (source/target ratio).
- y_scale  in  FIX_LEN  vertical step.
- src_h_num  in  13  source width (1..MAX_H).
- src_v_num  in  13  source height.
- target_h_num  in  13  output width.
- target_v_num  in  13  output height.
- fifo_row_rdy  in  1  a full source row is available in the FIFO.
- fifo_data  in  PIX_WIDTH  FIFO read data, valid 1 cycle after rd_en.
- rd_en  out  1  FIFO read strobe.
- pix_data  out  PIX_WIDTH  output pixel.
- data_vaild  out  1  pix_data valid.
- row_done  out  1  pulse after the last pixel of each output row.
- frame_done  out  1  pulse once the frame is fully consumed.
- busy  out  1  high from frame_start until frame_done.
- DDR3_ADDR  out  DDR_AW  frame base write address.

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; counters and accumulators cleared. Reset mid-frame abandons the frame with no frame_done.
- IDLE:
  - frame_start latches all config. With bypass=1: scales = 1<<FRAC_BITS, target dims = source dims.
  - The FSM then moves to WAIT_ROW, clears src_row, dst_row and y_acc, and raises busy.
  - frame_start while busy is ignored.
- DDR3_ADDR:
  - Registered on the cycle after frame_start to H_STRIDE*(V_MAX - target_v_num).
  - Forced to 0 if target_v_num >= V_MAX.
  - Held constant until the next accepted frame_start.
- WAIT_ROW: on fifo_row_rdy, go to LOAD.
- LOAD:
  - rd_en is high for exactly src_h_num consecutive cycles.
  - Data is written to line RAM at address k one cycle after the k-th rd_en.
  - Once the last write lands, go to DECIDE.
- DECIDE:
  - If dst_row == target_v_num, go to DISCARD.
  - Else if (y_acc >> FRAC_BITS) == src_row, go to EMIT.
  - Else src_row++ and go to WAIT_ROW; the row is skipped.
- EMIT:
  - Issues target_h_num line-RAM reads at addr = min(x_acc >> FRAC_BITS, src_h_num-1); x_acc starts at 0 and adds x_scale per pixel.
  - RAM latency is 1 cycle, so pix_data and data_vaild appear 1 cycle after each read and are contiguous within the row.
  - No backpressure.
  - After the last pixel: row_done pulses, dst_row++, y_acc += y_scale, then return to DECIDE. This re-emits the same buffered row on upscale.
- DISCARD:
  - Remaining source rows (src_row+1 .. src_v_num-1) are each read fully with rd_en and dropped.
  - Then frame_done pulses for 1 cycle, busy falls, and the FSM returns to IDLE.
- Zero dimensions: target_h_num=0 or target_v_num=0 emits no pixels; all source rows are discarded, then frame_done.
- Arithmetic:
  - x_acc and y_acc are FIX_LEN+13 bits wide, unsigned, with no wrap within legal sizes.
  - The source index is clamped at the row/frame edge; y beyond src_v_num-1 is clamped to the last row.

Test Plan:
- bypass=1, 4x2 source, pixels 0..7 → output 0,1,2,3 / 4,5,6,7; two row_done pulses; exactly 8 rd_en cycles.
- 8x4 source, x/y_scale=0x200, target 4x2 → rows 0 and 2 emit cols 0,2,4,6; rows 1 and 3 are read but not emitted; frame_done after 32 rd_en.
- 2x2 source {A,B/C,D}, scale=0x080, target 4x4 → rows AABB, AABB, CCDD, CCDD; only 4 rd_en cycles total.
- target_v_num=200 → DDR3_ADDR=0x19000; target_v_num=400 → DDR3_ADDR=0.
- rstn asserted mid-EMIT → outputs 0 asynchronously; the next frame_start produces a clean, correct frame.
- Second frame_start pulse during LOAD → ignored; DDR3_ADDR and dimensions unchanged; frame completes normally.
